pps_generator: RTL and testbench

PPS_GENERATOR -- requirements
Module: pps_generator

---
 rtl/pps_generator.sv | 144 ++++++++++++++
 tb/tb_pps_generator.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pps_generator.sv
// Pulse-per-second generator: fires a registered PPS pulse whenever the
// phase-adjusted timestamp crosses a second boundary.
module pps_generator #(
    parameter int TIMESTAMP_WIDTH = 64,
    parameter int WIDTH_BITS      = 32
) (
    input  logic                       axi_aclk,
    input  logic                       axi_reset,
    input  logic [TIMESTAMP_WIDTH-1:0] stamp_counter,
    input  logic                       enable,
    input  logic [31:0]                phase_offset,
    input  logic [WIDTH_BITS-1:0]      pulse_width,
    output logic                       pps_tx,
    output logic                       pps_strobe,
    output logic [31:0]                pps_count,
    output logic [15:0]                resync_count
);

    localparam int TW = TIMESTAMP_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRIME,
        ST_WAIT,
        ST_PULSE
    } state_t;

    function automatic logic [WIDTH_BITS-1:0] load_width(input logic [WIDTH_BITS-1:0] pw);
        return (pw == '0) ? '0 : pw - WIDTH_BITS'(1);
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Only the seconds field of adj is needed downstream; the fraction
    // contributes solely through the borrow of the 64-bit subtraction.
    logic [31:0] adj_sec_d, adj_sec_q, adj_prev_sec_q;
    logic [31:0] delta;
    logic        edge_evt_d, edge_evt_q;
    logic        jump_evt_d, jump_evt_q;

    always_comb begin
        adj_sec_d  = stamp_counter[TW-1 -: 32]
                     - {31'd0, (stamp_counter[31:0] < phase_offset)};
        delta      = adj_sec_q - adj_prev_sec_q;
        edge_evt_d = (delta == 32'd1);
        jump_evt_d = (delta > 32'd1);
    end

    always_ff @(posedge axi_aclk or posedge axi_reset) begin
        if (axi_reset) begin
            adj_sec_q      <= '0;
            adj_prev_sec_q <= '0;
            edge_evt_q     <= 1'b0;
            jump_evt_q     <= 1'b0;
        end else begin
            adj_sec_q      <= adj_sec_d;
            adj_prev_sec_q <= adj_sec_q;
            edge_evt_q     <= edge_evt_d;
            jump_evt_q     <= jump_evt_d;
        end
    end

    state_t                  state_q;
    logic                    prime_cnt_q;
    logic [WIDTH_BITS-1:0]   timer_q;
    logic                    pps_tx_q, pps_strobe_q;
    logic [31:0]             pps_count_q;
    logic [15:0]             resync_count_q;

    // Enable low overrides everything, including a same-cycle edge event.
    always_ff @(posedge axi_aclk or posedge axi_reset) begin
        if (axi_reset) begin
            state_q        <= ST_IDLE;
            prime_cnt_q    <= 1'b0;
            timer_q        <= '0;
            pps_tx_q       <= 1'b0;
            pps_strobe_q   <= 1'b0;
            pps_count_q    <= '0;
            resync_count_q <= '0;
        end else begin
            pps_strobe_q <= 1'b0;
            if (!enable) begin
                state_q  <= ST_IDLE;
                pps_tx_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q     <= ST_PRIME;
                        prime_cnt_q <= 1'b0;
                    end
                    ST_PRIME: begin
                        if (prime_cnt_q) begin
                            state_q <= ST_WAIT;
                        end else begin
                            prime_cnt_q <= 1'b1;
                        end
                    end
                    ST_WAIT: begin
                        if (jump_evt_q) begin
                            resync_count_q <= sat_inc16(resync_count_q);
                            prime_cnt_q    <= 1'b0;
                            state_q        <= ST_PRIME;
                        end else if (edge_evt_q) begin
                            timer_q      <= load_width(pulse_width);
                            pps_tx_q     <= 1'b1;
                            pps_strobe_q <= 1'b1;
                            pps_count_q  <= pps_count_q + 32'd1;
                            state_q      <= ST_PULSE;
                        end
                    end
                    ST_PULSE: begin
                        if (jump_evt_q) begin
                            pps_tx_q       <= 1'b0;
                            resync_count_q <= sat_inc16(resync_count_q);
                            prime_cnt_q    <= 1'b0;
                            state_q        <= ST_PRIME;
                        end else if (edge_evt_q) begin
                            timer_q      <= load_width(pulse_width);
                            pps_strobe_q <= 1'b1;
                            pps_count_q  <= pps_count_q + 32'd1;
                        end else if (timer_q == '0) begin
                            pps_tx_q <= 1'b0;
                            state_q  <= ST_WAIT;
                        end else begin
                            timer_q <= timer_q - WIDTH_BITS'(1);
                        end
                    end
                    default: begin
                        state_q  <= ST_IDLE;
                        pps_tx_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign pps_tx       = pps_tx_q;
    assign pps_strobe   = pps_strobe_q;
    assign pps_count    = pps_count_q;
    assign resync_count = resync_count_q;

endmodule

// File: tb/tb_pps_generator.sv
// Scoreboard bench for pps_generator: stimulus pushes expected strobe
// cycles, counts and pulse lengths; a negedge monitor pops and compares.
module tb_pps_generator;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [63:0] stamp;
    logic [31:0] po;
    logic [31:0] pw;
    logic        pps_tx, pps_strobe;
    logic [31:0] pps_count;
    logic [15:0] resync_count;

    pps_generator #(.TIMESTAMP_WIDTH(64), .WIDTH_BITS(32)) dut (
        .axi_aclk      (clk),
        .axi_reset     (rst),
        .stamp_counter (stamp),
        .enable        (enable),
        .phase_offset  (po),
        .pulse_width   (pw),
        .pps_tx        (pps_tx),
        .pps_strobe    (pps_strobe),
        .pps_count     (pps_count),
        .resync_count  (resync_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    int exp_cyc_q[$];
    int exp_cnt_q[$];
    int exp_len_q[$];
    int run_len = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one stamp value; if it is a crossing, the strobe shows 3 cycles later.
    task automatic tick(input logic [63:0] v, input bit pulse = 1'b0,
                        input int cnt = 0, input int len = 0);
        @(posedge clk);
        #1;
        stamp = v;
        if (pulse) begin
            exp_cyc_q.push_back(cyc + 3);
            exp_cnt_q.push_back(cnt);
        end
        if (len > 0) exp_len_q.push_back(len);
    endtask

    task automatic hold(input int n);
        repeat (n) tick(stamp);
    endtask

    always @(negedge clk) begin
        if (pps_strobe) begin
            if (exp_cyc_q.size() == 0) begin
                chk("unexpected_strobe", cyc, -1);
            end else begin
                chk("strobe_cycle", cyc, exp_cyc_q.pop_front());
                chk("strobe_count", pps_count, exp_cnt_q.pop_front());
            end
        end
        if (pps_tx) begin
            run_len++;
        end else if (run_len > 0) begin
            if (exp_len_q.size() == 0) chk("unexpected_pulse_len", run_len, -1);
            else                       chk("pulse_len", run_len, exp_len_q.pop_front());
            run_len = 0;
        end
    end

    initial begin
        rst    = 1'b1;
        enable = 1'b0;
        stamp  = 64'd0;
        po     = 32'd0;
        pw     = 32'd5;
        #12;
        chk("reset_tx", pps_tx, 0);
        chk("reset_strobe", pps_strobe, 0);
        chk("reset_count", pps_count, 0);
        chk("reset_resync", resync_count, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Basic crossing, width 5
        enable = 1'b1;
        for (int i = 0; i < 10; i++) tick(64'h0_FFFFF000 + 64'(28 * i));
        tick(64'h0_FFFFFFF0);
        tick(64'h1_0000000C, 1'b1, 1, 5);
        for (int i = 1; i <= 12; i++) tick(64'h1_0000000C + 64'(28 * i));
        chk("basic_count", pps_count, 1);
        chk("basic_tx_low", pps_tx, 0);

        // Phase offset of half a second
        enable = 1'b0;
        hold(2);
        po = 32'h8000_0000;
        tick(64'h5_7FFFFF00);
        hold(4);
        enable = 1'b1;
        for (int i = 1; i <= 6; i++) tick(64'h5_7FFFFF00 + 64'(16 * i));
        tick(64'h5_80000000, 1'b1, 2, 5);
        hold(8);
        tick(64'h6_00000000);
        hold(8);
        chk("phase_count", pps_count, 2);

        // Forward jump
        enable = 1'b0;
        po = 32'd0;
        tick(64'h3_00000000);
        hold(3);
        enable = 1'b1;
        for (int i = 1; i <= 6; i++) tick(64'h3_00000000 + 64'(2 * i));
        tick(64'h3_00000010);
        tick(64'h9_00000000);
        hold(6);
        chk("jump_resync", resync_count, 1);
        chk("jump_count", pps_count, 2);
        chk("jump_tx_low", pps_tx, 0);
        tick(64'hA_00000000, 1'b1, 3, 5);
        hold(8);

        // Zero width behaves as one cycle
        pw = 32'd0;
        tick(64'hB_00000000, 1'b1, 4, 1);
        hold(6);

        // Retrigger: width 100, edges 50 cycles apart
        pw = 32'd100;
        tick(64'hC_00000000, 1'b1, 5, 150);
        repeat (49) tick(64'hC_00000001);
        tick(64'hD_00000000, 1'b1, 6, 0);
        hold(110);
        chk("retrig_count", pps_count, 6);

        // Jump to top of range, seconds wrap, then backward jump
        pw = 32'd5;
        tick(64'hFFFFFFFF_00000000);
        hold(6);
        chk("wrapjump_resync", resync_count, 2);
        tick(64'h0, 1'b1, 7, 5);
        hold(8);
        tick(64'hFFFFFFFF_80000000);
        hold(6);
        chk("backjump_resync", resync_count, 3);
        chk("backjump_count", pps_count, 7);

        // Disable on second cycle of a 10-cycle pulse
        pw = 32'd10;
        tick(64'h0, 1'b1, 8, 2);
        hold(4);
        enable = 1'b0;
        hold(3);
        chk("disable_tx", pps_tx, 0);
        chk("disable_count_held", pps_count, 8);
        chk("disable_resync_held", resync_count, 3);

        // Asynchronous reset mid-pulse
        enable = 1'b1;
        hold(6);
        tick(64'h1_00000000, 1'b1, 9, 2);
        hold(4);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_tx", pps_tx, 0);
        chk("async_rst_strobe", pps_strobe, 0);
        chk("async_rst_count", pps_count, 0);
        chk("async_rst_resync", resync_count, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        hold(3);

        chk("pending_strobes", exp_cyc_q.size(), 0);
        chk("pending_lengths", exp_len_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
